// File: rtl/qysys_pio_in_debounced.sv
// ---------------------------------------------------------------------------
// qysys_pio_in_debounced
//
// Avalon-MM slave input port for board switches and buttons. Every raw pin
// is synchronised, debounced, and edge-detected; detected edges are latched
// in EDGE_CAPTURE and combined with IRQ_MASK into a level interrupt.
//
// Register map (word addresses):
//   0 DATA          RO   debounced input levels, zero-extended
//   1 reserved      RO   reads 0
//   2 IRQ_MASK      RW   bits [WIDTH-1:0]
//   3 EDGE_CAPTURE  R/W1C
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   address    register select (word address)
//   write      single-cycle write strobe
//   writedata  write data
//   in_port    raw asynchronous pin inputs
//   readdata   registered read data (latency 1, no read strobe)
//   irq        level interrupt, active high
// ---------------------------------------------------------------------------
module qysys_pio_in_debounced #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] w1c_bits;
    logic [31:0]      rd_mux;

    // Upper writedata bits are architecturally ignored.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // ---- Stage: metastability synchroniser ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= '0;
            end
        end else begin
            sync_ff[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_ff[s] <= sync_ff[s-1];
            end
        end
    end

    assign sync_lvl = sync_ff[SYNC_STAGES-1];

    // ---- Stage: per-bit debounce ----
    // A differing level must be seen for DEBOUNCE_CYCLES consecutive cycles;
    // returning to the stable level at any point restarts the count.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync_lvl[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable <= stable ^ accept;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Edges are taken from the accept event itself, so capture is set on the
    // same clock edge at which stable changes.
    always_comb begin
        case (EDGE_MODE)
            0:       edge_det = accept & sync_lvl;
            1:       edge_det = accept & ~sync_lvl;
            default: edge_det = accept;
        endcase
    end

    // ---- Stage: register file and read port ----
    assign w1c_bits = (write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = stable;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata     <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            // Read sees pre-write register values.
            readdata <= rd_mux;
            if (write && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // A new edge wins over a simultaneous W1C of the same bit.
            edge_capture <= (edge_capture & ~w1c_bits) | edge_det;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
